ram_dp_param: RTL and testbench

Parametrised simple-dual-port synchronous RAM. It supersedes the fixed 1024x8 single-port RAM.
- One write port with byte enables, plus one independent read port.
- Read latency is 1 or 2 cycles, with a rd_valid strobe.
- Read-during-write collision mode is selectable.
- A hardware clear engine zeroes the array after reset or on request.
- It sits under datapath blocks on the Basys3 designs as a generic scratch or frame buffer.

---
 rtl/ram_pkg.sv | 16 +
 rtl/ram_dp_core.sv | 71 +++++++
 rtl/ram_dp_param.sv | 143 ++++++++++++++
 tb/tb_ram_dp_param.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared types and helpers for the parametrised dual-port RAM
package ram_pkg;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    function automatic int be_width(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/ram_dp_core.sv
// rtl/ram_dp_core.sv - storage array, byte-lane write merge and first read stage
module ram_dp_core
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int DEPTH      = 1024,
    parameter int RDW_MODE   = RDW_READ_FIRST
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             we,
    input  logic [ADDR_WIDTH-1:0]            waddr,
    input  logic [DATA_WIDTH-1:0]            wdata,
    input  logic [be_width(DATA_WIDTH)-1:0]  wbe,
    input  logic                             re,
    input  logic [ADDR_WIDTH-1:0]            raddr,
    output logic [DATA_WIDTH-1:0]            rdata
);

    localparam int                  BE_WIDTH    = be_width(DATA_WIDTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_EXT   = (ADDR_WIDTH + 1)'(DEPTH);
    localparam bit                  WRITE_FIRST = (RDW_MODE == RDW_WRITE_FIRST);

    generate
        if (RDW_MODE != RDW_READ_FIRST && RDW_MODE != RDW_WRITE_FIRST) begin : g_bad_mode
            $error("ram_dp_core: RDW_MODE must be 0 or 1");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] old_word;
    logic [DATA_WIDTH-1:0] merged;
    logic                  waddr_ok;
    logic                  raddr_ok;

    assign waddr_ok = {1'b0, waddr} < DEPTH_EXT;
    assign raddr_ok = {1'b0, raddr} < DEPTH_EXT;

    // Merged word is shared by the array write and the write-first bypass.
    always_comb begin
        old_word = waddr_ok ? mem[waddr] : '0;
        merged   = old_word;
        for (int i = 0; i < BE_WIDTH; i++) begin
            if (wbe[i]) begin
                merged[8*i +: 8] = wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (we && waddr_ok) begin
            mem[waddr] <= merged;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            if (!raddr_ok) begin
                rdata <= '0;
            end else if (WRITE_FIRST && we && (waddr == raddr)) begin
                rdata <= merged;
            end else begin
                rdata <= mem[raddr];
            end
        end
    end

endmodule

// File: rtl/ram_dp_param.sv
// rtl/ram_dp_param.sv - simple-dual-port RAM with clear engine and 1/2-cycle read latency
module ram_dp_param
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 10,
    parameter int DEPTH         = 1024,
    parameter int RD_LATENCY    = 1,
    parameter int RDW_MODE      = RDW_READ_FIRST,
    parameter int INIT_ON_RESET = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             wr_en,
    input  logic [ADDR_WIDTH-1:0]            wr_addr,
    input  logic [DATA_WIDTH-1:0]            wr_data,
    input  logic [be_width(DATA_WIDTH)-1:0]  wr_be,
    input  logic                             rd_en,
    input  logic [ADDR_WIDTH-1:0]            rd_addr,
    output logic [DATA_WIDTH-1:0]            rd_data,
    output logic                             rd_valid,
    input  logic                             clr_start,
    output logic                             busy
);

    localparam int                    BE_WIDTH  = be_width(DATA_WIDTH);
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    generate
        if (DATA_WIDTH % 8 != 0 || DEPTH > 2**ADDR_WIDTH || RD_LATENCY < 1 || RD_LATENCY > 2)
        begin : g_bad_params
            $error("ram_dp_param: illegal parameter combination");
        end
    endgenerate

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   cnt;
    logic                    init_pending;
    logic                    clr_go;
    logic                    wr_fire;
    logic                    rd_fire;
    logic                    core_we;
    logic [ADDR_WIDTH-1:0]   core_waddr;
    logic [DATA_WIDTH-1:0]   core_wdata;
    logic [BE_WIDTH-1:0]     core_wbe;
    logic [DATA_WIDTH-1:0]   core_rdata;
    logic                    rd_v1;

    // A starting sweep takes priority over a user write in the same cycle.
    assign clr_go  = (state == ST_IDLE) && (clr_start || init_pending);
    assign wr_fire = wr_en && !busy && !clr_go && ({1'b0, wr_addr} < DEPTH_EXT);
    assign rd_fire = rd_en && !busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            busy         <= 1'b0;
            cnt          <= '0;
            init_pending <= (INIT_ON_RESET != 0);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (clr_go) begin
                        state        <= ST_CLEAR;
                        busy         <= 1'b1;
                        cnt          <= '0;
                        init_pending <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    if (cnt == LAST_ADDR) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + ADDR_WIDTH'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign core_we    = busy || wr_fire;
    assign core_waddr = busy ? cnt : wr_addr;
    assign core_wdata = busy ? '0 : wr_data;
    assign core_wbe   = busy ? '1 : wr_be;

    ram_dp_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH),
        .RDW_MODE   (RDW_MODE)
    ) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (core_we),
        .waddr (core_waddr),
        .wdata (core_wdata),
        .wbe   (core_wbe),
        .re    (rd_fire),
        .raddr (rd_addr),
        .rdata (core_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_v1 <= 1'b0;
        end else begin
            rd_v1 <= rd_fire;
        end
    end

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic                  rd_v2;
            logic [DATA_WIDTH-1:0] rd_q2;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_v2 <= 1'b0;
                    rd_q2 <= '0;
                end else begin
                    rd_v2 <= rd_v1;
                    if (rd_v1) begin
                        rd_q2 <= core_rdata;
                    end
                end
            end

            assign rd_data  = rd_q2;
            assign rd_valid = rd_v2;
        end else begin : g_lat1
            assign rd_data  = core_rdata;
            assign rd_valid = rd_v1;
        end
    endgenerate

endmodule

// File: tb/tb_ram_dp_param.sv
// tb/tb_ram_dp_param.sv - randomized bench for ram_dp_param against a behavioural memory model
module tb_ram_dp_param;

    typedef struct {
        logic [31:0] val;
        int          due;
    } rd_exp_t;

    // Index 0: default 1024x8, latency 1, read-first, init on reset.
    // Index 1: 40x32, latency 2, write-first, no init.
    int dep     [2] = '{1024, 40};
    int lat     [2] = '{1, 2};
    int wfirst  [2] = '{0, 1};
    int lanes   [2] = '{1, 4};
    bit init_on [2] = '{1'b1, 1'b0};

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en     [2];
    logic [9:0]  wr_addr   [2];
    logic [31:0] wr_data   [2];
    logic [3:0]  wr_be     [2];
    logic        rd_en     [2];
    logic [9:0]  rd_addr   [2];
    logic        clr_start [2];

    logic [7:0]  rd_data_a;
    logic [31:0] rd_data_b;
    logic        rd_valid_a, rd_valid_b, busy_a, busy_b;

    logic [31:0] mdl [2][1024];
    int          mbusy [2];
    bit          pend  [2];
    logic [31:0] last  [2];
    rd_exp_t     q     [2][$];
    int          cyc = 0;
    int          n_vec = 0;
    int          n_miss = 0;
    int          n;

    always #5 clk = ~clk;

    ram_dp_param #(
        .DATA_WIDTH(8), .ADDR_WIDTH(10), .DEPTH(1024),
        .RD_LATENCY(1), .RDW_MODE(0), .INIT_ON_RESET(1)
    ) dut_a (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0][7:0]), .wr_be(wr_be[0][0:0]),
        .rd_en(rd_en[0]), .rd_addr(rd_addr[0]), .rd_data(rd_data_a), .rd_valid(rd_valid_a),
        .clr_start(clr_start[0]), .busy(busy_a)
    );

    ram_dp_param #(
        .DATA_WIDTH(32), .ADDR_WIDTH(6), .DEPTH(40),
        .RD_LATENCY(2), .RDW_MODE(1), .INIT_ON_RESET(0)
    ) dut_b (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en[1]), .wr_addr(wr_addr[1][5:0]), .wr_data(wr_data[1]), .wr_be(wr_be[1]),
        .rd_en(rd_en[1]), .rd_addr(rd_addr[1][5:0]), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
        .clr_start(clr_start[1]), .busy(busy_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] obs_data(input int d);
        return (d != 0) ? rd_data_b : {24'h0, rd_data_a};
    endfunction

    function automatic logic [31:0] obs_valid(input int d);
        return {31'h0, (d != 0) ? rd_valid_b : rd_valid_a};
    endfunction

    function automatic logic [31:0] obs_busy(input int d);
        return {31'h0, (d != 0) ? busy_b : busy_a};
    endfunction

    // Reference model: whole-array view, a sweep is a countdown plus an instant zero fill.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                mbusy[d] = 0;
                pend[d]  = init_on[d];
            end
        end else begin
            cyc++;
            for (int d = 0; d < 2; d++) begin
                bit          idle, go, wr_ok;
                logic [31:0] merged;
                rd_exp_t     e;
                idle   = (mbusy[d] == 0);
                go     = idle && (pend[d] || clr_start[d]);
                wr_ok  = idle && !go && wr_en[d] && (wr_addr[d] < dep[d]);
                merged = mdl[d][wr_addr[d]];
                for (int i = 0; i < lanes[d]; i++)
                    if (wr_be[d][i]) merged[8*i +: 8] = wr_data[d][8*i +: 8];
                if (idle && rd_en[d]) begin
                    if (rd_addr[d] >= dep[d])
                        e.val = 32'h0;
                    else if (wfirst[d] != 0 && wr_ok && wr_addr[d] == rd_addr[d])
                        e.val = merged;
                    else
                        e.val = mdl[d][rd_addr[d]];
                    e.due = cyc + lat[d] - 1;
                    q[d].push_back(e);
                end
                if (wr_ok) mdl[d][wr_addr[d]] = merged;
                if (go) begin
                    pend[d]  = 1'b0;
                    mbusy[d] = dep[d];
                    for (int i = 0; i < dep[d]; i++) mdl[d][i] = 32'h0;
                end else if (!idle) begin
                    mbusy[d]--;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                q[d].delete();
                last[d] = 32'h0;
            end
            if (q[d].size() > 0 && q[d][0].due == cyc) begin
                check((d != 0) ? "b_rd_valid" : "a_rd_valid", obs_valid(d), 32'h1);
                check((d != 0) ? "b_rd_data" : "a_rd_data", obs_data(d), q[d][0].val);
                last[d] = q[d][0].val;
                void'(q[d].pop_front());
            end else begin
                check((d != 0) ? "b_rd_valid" : "a_rd_valid", obs_valid(d), 32'h0);
                check((d != 0) ? "b_rd_hold" : "a_rd_hold", obs_data(d), last[d]);
            end
            check((d != 0) ? "b_busy" : "a_busy", obs_busy(d), {31'h0, mbusy[d] > 0});
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
        for (int d = 0; d < 2; d++) begin
            wr_en[d]     = 1'b0;
            rd_en[d]     = 1'b0;
            clr_start[d] = 1'b0;
        end
    endtask

    task automatic wr(input int d, input int a, input logic [31:0] v, input logic [3:0] be);
        wr_en[d]   = 1'b1;
        wr_addr[d] = a[9:0];
        wr_data[d] = v;
        wr_be[d]   = be;
    endtask

    task automatic rd(input int d, input int a);
        rd_en[d]   = 1'b1;
        rd_addr[d] = a[9:0];
    endtask

    task automatic count_busy_a(output int cnt);
        cnt = 0;
        while (busy_a && cnt < 3000) begin
            tick();
            cnt++;
        end
    endtask

    function automatic int rand_addr(input int d);
        if (d != 0) return int'($urandom_range(0, 63));
        if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 1023));
        return int'($urandom_range(0, 15));
    endfunction

    initial begin
        for (int d = 0; d < 2; d++) begin
            wr_en[d] = 1'b0; wr_addr[d] = '0; wr_data[d] = '0; wr_be[d] = '0;
            rd_en[d] = 1'b0; rd_addr[d] = '0; clr_start[d] = 1'b0;
            for (int i = 0; i < 1024; i++) mdl[d][i] = 32'h0;
        end
        repeat (3) tick();

        // Release reset: A sweeps on its own, B is cleared on request.
        rst_n = 1'b1;
        clr_start[1] = 1'b1;
        tick();
        count_busy_a(n);
        check("a_init_sweep_len", n, 1024);
        rd(0, 1023);
        tick();
        check("a_read_1023", {24'h0, rd_data_a}, 32'h0);
        tick();

        wr(0, 0, 32'hAA, 4'h1);    tick();
        wr(0, 50, 32'hBB, 4'h1);   tick();
        wr(0, 1023, 32'hCC, 4'h1); tick();
        rd(0, 0);    tick();
        rd(0, 50);   tick();
        rd(0, 1023); tick();
        repeat (2) tick();

        wr(1, 5, 32'h11223344, 4'hF); tick();
        wr(1, 5, 32'hFFFFFFFF, 4'b0010); tick();
        rd(1, 5); tick(); tick();
        check("b_be_merge", rd_data_b, 32'h1122FF44);
        tick();

        wr(0, 7, 32'h12, 4'h1); wr(1, 7, 32'h12, 4'hF); tick();
        wr(0, 7, 32'h34, 4'h1); rd(0, 7); wr(1, 7, 32'h34, 4'hF); rd(1, 7); tick();
        check("a_rdw_read_first", {24'h0, rd_data_a}, 32'h12);
        tick();
        check("b_rdw_write_first", rd_data_b, 32'h34);
        rd(0, 7); rd(1, 7); tick();
        repeat (3) tick();

        clr_start[0] = 1'b1; tick();
        wr(0, 50, 32'h55, 4'h1); tick();
        count_busy_a(n);
        check("a_req_sweep_rest", n, 1023);
        rd(0, 50); tick();
        check("a_cleared_word", {24'h0, rd_data_a}, 32'h0);
        tick();

        // Reset in the middle of a sweep with a B read in flight.
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
        repeat (299) tick();
        rd(1, 3); tick();
        #1 rst_n = 1'b0;
        #1;
        check("a_busy_on_reset", {31'h0, busy_a}, 32'h0);
        check("b_valid_on_reset", {31'h0, rd_valid_b}, 32'h0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        count_busy_a(n);
        check("a_resweep_len", n, 1024);

        for (int i = 0; i < 1500; i++) begin
            for (int d = 0; d < 2; d++) begin
                if ($urandom_range(0, 2) == 0)
                    wr(d, rand_addr(d), $urandom, 4'($urandom_range(0, 15)));
                if ($urandom_range(0, 1) == 1)
                    rd(d, rand_addr(d));
            end
            if ($urandom_range(0, 99) == 0) clr_start[1] = 1'b1;
            if (i == 700) clr_start[0] = 1'b1;
            tick();
        end
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
